seq_chunk_adder: RTL and testbench

//   Parametrised multi-cycle two's-complement adder/subtractor with valid/ready handshakes on input and output.

---
 rtl/seq_chunk_adder_pkg.sv | 20 ++
 rtl/seq_chunk_adder_chunk.sv | 21 ++
 rtl/seq_chunk_adder.sv | 135 +++++++++++++
 tb/tb_seq_chunk_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
`default_nettype none
// ============================================================
// seq_chunk_adder_pkg : shared FSM encoding and sizing helper
// Rev 1.0
// ============================================================
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Counter must stay at least one bit wide even when a single chunk covers the word
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_chunk_adder_chunk.sv
`default_nettype none
// ============================================================
// chunk_adder : combinational CHUNK-bit adder with carry in/out
// Rev 1.0
// ============================================================
module chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};

endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================
// seq_chunk_adder : multi-cycle two's-complement add/sub, one
//                   CHUNK per cycle, valid/ready on both sides
// Rev 1.0
// ============================================================
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic             iC,
    input  logic             iSub,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData,
    output logic             oData_C,
    output logic             oOverflow
);

    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
    localparam int CNT_W      = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    if (CHUNK < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_param_check
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_sum;
    logic               w_co;

    // One adder serves every chunk; the counter steers which slice it sees
    assign w_a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
    assign w_b_chunk = b_q[cnt_q*CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i  (w_a_chunk),
        .b_i  (w_b_chunk),
        .ci_i (carry_q),
        .s_o  (w_sum),
        .co_o (w_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (iValid) begin
                    // Subtraction folds into A + ~B + ~borrow, so RUN only ever adds
                    a_d     = iData_a;
                    b_d     = iSub ? ~iData_b : iData_b;
                    carry_d = iSub ? ~iC : iC;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[cnt_q*CHUNK +: CHUNK] = w_sum;
                carry_d = w_co;
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d   = '0;
                    cout_d  = w_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (iReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oReady    = (state_q == S_IDLE);
    assign oValid    = (state_q == S_DONE);
    assign oData     = res_q;
    assign oData_C   = cout_q;
    assign oOverflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================
// tb_seq_chunk_adder : three DUTs (CHUNK 8/32/4) against a word-level model
// Rev 1.0
// ============================================================
module tb_seq_chunk_adder;

    localparam int     W    = 32;
    localparam int     NI   = 3;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk;
    logic          rst_n;
    logic          valid;
    logic          cin;
    logic          sub;
    logic [W-1:0]  da;
    logic [W-1:0]  db;
    logic [NI-1:0] rdy;
    logic [NI-1:0] ordy;
    logic [NI-1:0] oval;
    logic [NI-1:0] oc;
    logic [NI-1:0] oo;
    logic [W-1:0]  od [NI];

    int            total;
    int            bad;
    logic [NI-1:0] busy;
    logic [NI-1:0] fresh;
    int            edges [NI];
    logic [W-1:0]  exp_d [NI];
    logic [NI-1:0] exp_c;
    logic [NI-1:0] exp_o;
    logic [NI-1:0] lit_has;
    logic [W-1:0]  lit_d [NI];
    logic [NI-1:0] lit_c;
    logic [NI-1:0] lit_o;
    logic          cur_lit_on;
    logic [W-1:0]  cur_lit_d;
    logic          cur_lit_c;
    logic          cur_lit_o;
    logic          rand_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CH = (g == 0) ? 8 : ((g == 1) ? 32 : 4);
        seq_chunk_adder #(
            .WIDTH (W),
            .CHUNK (CH)
        ) u_dut (
            .iClk      (clk),
            .iRst_n    (rst_n),
            .iValid    (valid),
            .oReady    (ordy[g]),
            .iData_a   (da),
            .iData_b   (db),
            .iC        (cin),
            .iSub      (sub),
            .oValid    (oval[g]),
            .iReady    (rdy[g]),
            .oData     (od[g]),
            .oData_C   (oc[g]),
            .oOverflow (oo[g])
        );
    end

    function automatic int chunk_of(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 32 : 4);
    endfunction

    // Word-level arithmetic: unsigned view gives carry/no-borrow, signed view gives overflow
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic s,
                                  output logic [W-1:0] d, output logic co, output logic ov);
        longint ua, ub, sa, sb, lc, ur, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lc = longint'(c);
        if (!s) begin
            ur = ua + ub + lc;
            sr = sa + sb + lc;
            co = (ur >= 64'sh1_0000_0000);
        end else begin
            ur = ua - ub - lc;
            sr = sa - sb - lc;
            co = (ua >= ub + lc);
        end
        d  = ur[W-1:0];
        ov = (sr > SMAX) || (sr < SMIN);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d(chunk=%0d) got=%h want=%h", nm, i, chunk_of(i), act, exp);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] md;
        logic         mc, mo, ev, er;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                busy[i]  = 1'b0;
                fresh[i] = 1'b1;
            end
            if (busy[i]) edges[i]++;
            ev = busy[i] && (edges[i] >= W / chunk_of(i));
            er = !busy[i];
            chk("oValid", i, W'(oval[i]), W'(ev));
            chk("oReady", i, W'(ordy[i]), W'(er));
            if (ev) begin
                chk("oData", i, od[i], exp_d[i]);
                chk("oData_C", i, W'(oc[i]), W'(exp_c[i]));
                chk("oOverflow", i, W'(oo[i]), W'(exp_o[i]));
                if (lit_has[i]) begin
                    chk("lit_data", i, od[i], lit_d[i]);
                    chk("lit_C", i, W'(oc[i]), W'(lit_c[i]));
                    chk("lit_ovf", i, W'(oo[i]), W'(lit_o[i]));
                end
            end else if (fresh[i]) begin
                chk("rst_data", i, od[i], '0);
                chk("rst_C", i, W'(oc[i]), '0);
                chk("rst_ovf", i, W'(oo[i]), '0);
            end
            if (rst_n && ev && rdy[i]) begin
                busy[i] = 1'b0;
            end else if (rst_n && !busy[i] && valid) begin
                model(da, db, cin, sub, md, mc, mo);
                exp_d[i]   = md;
                exp_c[i]   = mc;
                exp_o[i]   = mo;
                busy[i]    = 1'b1;
                edges[i]   = -1;
                fresh[i]   = 1'b0;
                lit_has[i] = cur_lit_on;
                lit_d[i]   = cur_lit_d;
                lit_c[i]   = cur_lit_c;
                lit_o[i]   = cur_lit_o;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            for (int i = 0; i < NI; i++) rdy[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy != '0 && n < 300) begin
            cycle();
            n++;
        end
        chk("drain", 0, W'(busy), '0);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s,
                         input logic lon, input logic [W-1:0] ld, input logic lc, input logic lo);
        wait_idle();
        da         = a;
        db         = b;
        cin        = c;
        sub        = s;
        valid      = 1'b1;
        cur_lit_on = lon;
        cur_lit_d  = ld;
        cur_lit_c  = lc;
        cur_lit_o  = lo;
        cycle();
        valid      = 1'b0;
        cur_lit_on = 1'b0;
        da         = $urandom;
        db         = $urandom;
        cin        = 1'($urandom);
        sub        = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        busy       = '0;
        fresh      = '1;
        exp_c      = '0;
        exp_o      = '0;
        lit_has    = '0;
        lit_c      = '0;
        lit_o      = '0;
        rand_rdy   = 1'b0;
        rdy        = '1;
        valid      = 1'b0;
        da         = '0;
        db         = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        cur_lit_on = 1'b0;
        cur_lit_d  = '0;
        cur_lit_c  = 1'b0;
        cur_lit_o  = 1'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < NI; i++) begin
            edges[i] = 0;
            exp_d[i] = '0;
            lit_d[i] = '0;
        end
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // Hand-computed results pin the model on every CHUNK variant
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        issue(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0);
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0);
        wait_idle();

        // Backpressure on the CHUNK=8 instance while iValid keeps pulsing
        rdy = 3'b110;
        issue(32'h0000_1234, 32'h0000_0FF0, 1'b0, 1'b0, 1'b1, 32'h0000_2224, 1'b0, 1'b0);
        repeat (4) cycle();
        for (int k = 0; k < 10; k++) begin
            valid = 1'b1;
            da    = $urandom;
            db    = $urandom;
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            cycle();
        end
        valid  = 1'b0;
        rdy[0] = 1'b1;
        cycle();
        cycle();
        wait_idle();

        // Asynchronous reset in the second RUN cycle of the CHUNK=8 instance
        rdy = '1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("async_oValid", i, W'(oval[i]), '0);
            chk("async_oReady", i, W'(ordy[i]), W'(1'b1));
            chk("async_oData", i, od[i], '0);
            chk("async_C", i, W'(oc[i]), '0);
            chk("async_ovf", i, W'(oo[i]), '0);
        end
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0);
        wait_idle();

        rand_rdy = 1'b1;
        for (int k = 0; k < 60; k++) begin
            issue(pick(), pick(), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0, 1'b0);
        end
        wait_idle();
        rand_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
